button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_pkg.sv | 17 +
 rtl/button_debounce_sync_2ff.sv | 24 ++
 rtl/button_debounce.sv | 124 ++++++++++++
 tb/tb_button_debounce.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button debouncer.
package button_pkg;

    typedef enum logic [1:0] {
        LOW,
        WAIT_HIGH,
        HIGH,
        WAIT_LOW
    } db_state_e;

    // Integer cycle count for a duration in ms; divide first so large clocks stay in 32 bits.
    function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                                 input int unsigned ms);
        return (clk_freq / 32'd1000) * ms;
    endfunction

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer with press/release pulses; optional long-press pulse
// enabled by defining BUTTON_DEBOUNCE_LONG_PRESS_EN.
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned LONG_MS     = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    output logic btn_db,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int unsigned N  = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

    logic          s;
    db_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic          btn_db_q;
    logic          btn_press_q;
    logic          btn_release_q;

    sync_2ff u_sync (
        .clk  (clk),
        .rst_n(reset_n),
        .d_i  (btn_in),
        .q_o  (s)
    );

    // Outputs are updated on the same edge as the state change so btn_db always tracks state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= LOW;
            cnt_q         <= '0;
            btn_db_q      <= 1'b0;
            btn_press_q   <= 1'b0;
            btn_release_q <= 1'b0;
        end else begin
            btn_press_q   <= 1'b0;
            btn_release_q <= 1'b0;
            case (state_q)
                LOW: begin
                    if (s) begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        state_q <= LOW;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q     <= HIGH;
                        btn_db_q    <= 1'b1;
                        btn_press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HIGH: begin
                    if (!s) begin
                        state_q <= WAIT_LOW;
                        cnt_q   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (s) begin
                        state_q <= HIGH;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q       <= LOW;
                        btn_db_q      <= 1'b0;
                        btn_release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= LOW;
            endcase
        end
    end

    assign btn_db      = btn_db_q;
    assign btn_press   = btn_press_q;
    assign btn_release = btn_release_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned L  = ms_to_cycles(CLK_FREQ, LONG_MS);
    localparam int unsigned HW = $clog2(L + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(L);

    logic [HW-1:0] hold_q;
    logic          btn_long_q;
    logic          leaving_high;

    assign leaving_high = (state_q == WAIT_LOW) && !s && (cnt_q == CNT_MAX);

    // Saturating at L leaves exactly one pulse per press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q     <= '0;
            btn_long_q <= 1'b0;
        end else begin
            btn_long_q <= 1'b0;
            if (!btn_db_q || leaving_high) begin
                hold_q <= '0;
            end else if (hold_q != HOLD_MAX) begin
                hold_q <= hold_q + HW'(1);
                if (hold_q == HOLD_MAX - HW'(1)) btn_long_q <= 1'b1;
            end
        end
    end

    assign btn_long = btn_long_q;
`else
    assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce at N=10, L=50 debounce/hold cycles.
module tb_button_debounce;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic btn_in = 1'b0;
    logic btn_db, btn_press, btn_release, btn_long;

    int n_cmp = 0;
    int n_err = 0;

    button_debounce #(
        .CLK_FREQ   (10_000),
        .DEBOUNCE_MS(1),
        .LONG_MS    (5)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_in     (btn_in),
        .btn_db     (btn_db),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        btn_in  = 1'b0;
        repeat (3) tick();
        n_cmp++; if (btn_db !== 1'b0) begin n_err++; $display("FAIL reset_db: got %b want 0", btn_db); end
        n_cmp++; if (btn_press !== 1'b0) begin n_err++; $display("FAIL reset_press: got %b want 0", btn_press); end
        n_cmp++; if (btn_release !== 1'b0) begin n_err++; $display("FAIL reset_release: got %b want 0", btn_release); end
        n_cmp++; if (btn_long !== 1'b0) begin n_err++; $display("FAIL reset_long: got %b want 0", btn_long); end
        reset_n = 1'b1;
        repeat (3) tick();
        n_cmp++; if (btn_db !== 1'b0) begin n_err++; $display("FAIL post_reset_db: got %b want 0", btn_db); end
    endtask

    task automatic test_press();
        logic exp_db, exp_pr;
        btn_in = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            exp_db = (e >= 13);
            exp_pr = (e == 13);
            n_cmp++; if (btn_db !== exp_db) begin n_err++; $display("FAIL press_db edge %0d: got %b want %b", e, btn_db, exp_db); end
            n_cmp++; if (btn_press !== exp_pr) begin n_err++; $display("FAIL press_pulse edge %0d: got %b want %b", e, btn_press, exp_pr); end
            n_cmp++; if (btn_release !== 1'b0) begin n_err++; $display("FAIL press_rel edge %0d: got %b want 0", e, btn_release); end
        end
    endtask

    task automatic test_release();
        logic exp_db, exp_rl;
        btn_in = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            tick();
            exp_db = (e < 13);
            exp_rl = (e == 13);
            n_cmp++; if (btn_db !== exp_db) begin n_err++; $display("FAIL release_db edge %0d: got %b want %b", e, btn_db, exp_db); end
            n_cmp++; if (btn_release !== exp_rl) begin n_err++; $display("FAIL release_pulse edge %0d: got %b want %b", e, btn_release, exp_rl); end
            n_cmp++; if (btn_press !== 1'b0) begin n_err++; $display("FAIL release_press edge %0d: got %b want 0", e, btn_press); end
        end
    endtask

    task automatic test_bounce();
        int presses = 0;
        int at = 0;
        logic [11:0] pat;
        pat = 12'b111_000_111_000;
        for (int i = 11; i >= 0; i--) begin
            btn_in = pat[i];
            tick();
            if (btn_press === 1'b1) presses++;
        end
        btn_in = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (btn_press === 1'b1) begin presses++; at = e; end
        end
        n_cmp++; if (presses != 1) begin n_err++; $display("FAIL bounce_count: got %0d want 1", presses); end
        n_cmp++; if (at != 13) begin n_err++; $display("FAIL bounce_latency: got %0d want 13", at); end
        btn_in = 1'b0;
        repeat (15) tick();
        n_cmp++; if (btn_db !== 1'b0) begin n_err++; $display("FAIL bounce_settle_db: got %b want 0", btn_db); end
    endtask

    task automatic test_glitch();
        int active = 0;
        btn_in = 1'b1;
        repeat (9) begin
            tick();
            if (btn_db || btn_press || btn_release) active++;
        end
        btn_in = 1'b0;
        repeat (20) begin
            tick();
            if (btn_db || btn_press || btn_release) active++;
        end
        n_cmp++; if (active != 0) begin n_err++; $display("FAIL glitch_activity: got %0d active cycles want 0", active); end
    endtask

    task automatic test_reset_mid();
        logic exp_pr;
        btn_in = 1'b1;
        repeat (8) tick();
        reset_n = 1'b0;
        #2;
        n_cmp++; if ({btn_db, btn_press, btn_release, btn_long} !== 4'b0000) begin
            n_err++; $display("FAIL midreset_outputs: got %b want 0000", {btn_db, btn_press, btn_release, btn_long});
        end
        tick();
        tick();
        n_cmp++; if ({btn_db, btn_press, btn_release, btn_long} !== 4'b0000) begin
            n_err++; $display("FAIL midreset_hold: got %b want 0000", {btn_db, btn_press, btn_release, btn_long});
        end
        reset_n = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            exp_pr = (e == 13);
            n_cmp++; if (btn_press !== exp_pr) begin n_err++; $display("FAIL midreset_press edge %0d: got %b want %b", e, btn_press, exp_pr); end
        end
    endtask

    task automatic test_long();
        int pe = -1;
        int longs = 0;
        int le = -1;
        int both = 0;
        btn_in = 1'b0;
        repeat (15) tick();
        btn_in = 1'b1;
        for (int c = 1; c <= 93; c++) begin
            tick();
            if (btn_press === 1'b1) pe = c;
            if (btn_long === 1'b1) begin longs++; le = c; end
            if (btn_press === 1'b1 && btn_release === 1'b1) both++;
        end
        n_cmp++; if (pe != 13) begin n_err++; $display("FAIL long_press_edge: got %0d want 13", pe); end
        n_cmp++; if (both != 0) begin n_err++; $display("FAIL long_press_and_release: got %0d want 0", both); end
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        n_cmp++; if (longs != 1) begin n_err++; $display("FAIL long_count: got %0d want 1", longs); end
        n_cmp++; if (le - pe != 50) begin n_err++; $display("FAIL long_delay: got %0d want 50", le - pe); end
`else
        n_cmp++; if (longs != 0) begin n_err++; $display("FAIL long_count: got %0d want 0", longs); end
`endif
        btn_in = 1'b0;
        repeat (20) begin
            tick();
            if (btn_long === 1'b1) longs++;
        end
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        n_cmp++; if (longs != 1) begin n_err++; $display("FAIL long_after_release: got %0d want 1", longs); end
`else
        n_cmp++; if (longs != 0) begin n_err++; $display("FAIL long_after_release: got %0d want 0", longs); end
`endif
        n_cmp++; if (btn_db !== 1'b0) begin n_err++; $display("FAIL long_final_db: got %b want 0", btn_db); end
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_glitch();
        test_reset_mid();
        test_long();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
